// File: rtl/ddr_port_arbiter_if.sv
// Bus bundle between NPORTS client requesters, the port arbiter and the DDR2 controller
// queues (address FIFO, write buffer, read buffer).
interface ddr_port_arbiter_if #(
    parameter int NPORTS = 4
);
    logic [NPORTS-1:0]        Req;
    logic [NPORTS-1:0]        ReqRead;
    logic [NPORTS-1:0][27:0]  ReqAddr;
    logic [NPORTS-1:0][127:0] ReqWData;
    logic [NPORTS-1:0]        Grant;
    logic [NPORTS-1:0]        WTake;
    logic [127:0]             RdData;
    logic [NPORTS-1:0]        RdValid;
    logic                     Orphan;
    logic [27:0]              Address;
    logic                     Read;
    logic                     WriteAF;
    logic                     AFfull;
    logic [127:0]             WriteData;
    logic                     WriteWB;
    logic                     WBfull;
    logic [127:0]             ReadData;
    logic                     ReadRB;
    logic                     RBempty;

    // master: the arbiter itself; slave: clients plus controller around it
    modport master (
        input  Req, ReqRead, ReqAddr, ReqWData, AFfull, WBfull, ReadData, RBempty,
        output Grant, WTake, RdData, RdValid, Orphan, Address, Read, WriteAF,
               WriteData, WriteWB, ReadRB
    );
    modport slave (
        output Req, ReqRead, ReqAddr, ReqWData, AFfull, WBfull, ReadData, RBempty,
        input  Grant, WTake, RdData, RdValid, Orphan, Address, Read, WriteAF,
               WriteData, WriteWB, ReadRB
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Arbitrates NPORTS burst requesters onto one DDR2 controller; read beats are steered back
// through an in-order tag FIFO. Define DDR_ARB_FIXED_PRI_EN for fixed priority (port 0 first).
module ddr_port_arbiter #(
    parameter int NPORTS   = 4,
    parameter int BEATS    = 2,
    parameter int TAGDEPTH = 16
) (
    input logic CLK,
    input logic Reset,
    ddr_port_arbiter_if.master bus
);
    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW = $clog2(TAGDEPTH);
    localparam int CW = $clog2(TAGDEPTH + 1);

    typedef enum logic [1:0] {IDLE, WDATA, ISSUE} state_t;

    state_t            state;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     pick;
    logic              found;
    logic [BW-1:0]     beat_cnt;
    logic [BW-1:0]     ret_cnt;
    logic [27:0]       lat_addr;
    logic              lat_read;
    logic [IW-1:0]     tag_mem [TAGDEPTH];
    logic [TW-1:0]     tag_wr;
    logic [TW-1:0]     tag_rd;
    logic [CW-1:0]     tag_cnt;
    logic              tag_full;
    logic              tag_empty;
    logic              orphan;
    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] win_oh;
    logic [NPORTS-1:0] head_oh;
    logic              wb_go;
    logic              af_go;
    logic              rb_go;
    logic              tag_push;
    logic              tag_pop;

    assign tag_full  = (tag_cnt == CW'(TAGDEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign eligible  = bus.Req & (~bus.ReqRead | {NPORTS{~tag_full}});

    // first eligible port scanning upward from rr_ptr, wrapping at NPORTS
    always_comb begin
        logic [IW:0] cand;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NPORTS; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NPORTS))
                cand = cand - (IW+1)'(NPORTS);
            if (!found && eligible[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    assign win_oh  = NPORTS'(1) << winner;
    assign head_oh = NPORTS'(1) << tag_mem[tag_rd];

    assign wb_go    = !Reset && (state == WDATA) && !bus.WBfull;
    assign af_go    = !Reset && (state == ISSUE) && !bus.AFfull;
    assign rb_go    = !Reset && !bus.RBempty && !tag_empty;
    assign tag_push = af_go && lat_read;
    assign tag_pop  = rb_go && (ret_cnt == BW'(BEATS - 1));

    assign bus.WriteWB   = wb_go;
    assign bus.WTake     = wb_go ? win_oh : '0;
    assign bus.WriteData = bus.ReqWData[winner];
    assign bus.WriteAF   = af_go;
    assign bus.Grant     = af_go ? win_oh : '0;
    assign bus.Address   = lat_addr;
    assign bus.Read      = lat_read;
    assign bus.ReadRB    = rb_go;
    assign bus.Orphan    = orphan;

`ifdef DDR_ARB_FIXED_PRI_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge CLK) begin
        if (Reset)
            rr_ptr <= '0;
        else if (af_go)
            rr_ptr <= (winner == IW'(NPORTS - 1)) ? '0 : winner + IW'(1);
    end
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            winner   <= '0;
            beat_cnt <= '0;
            lat_addr <= '0;
            lat_read <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        winner   <= pick;
                        lat_addr <= bus.ReqAddr[pick];
                        lat_read <= bus.ReqRead[pick];
                        beat_cnt <= '0;
                        state    <= bus.ReqRead[pick] ? ISSUE : WDATA;
                    end
                end
                WDATA: begin
                    if (wb_go) begin
                        if (beat_cnt == BW'(BEATS - 1)) begin
                            beat_cnt <= '0;
                            state    <= ISSUE;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (af_go)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (tag_push)
            tag_mem[tag_wr] <= winner;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
            ret_cnt <= '0;
            orphan  <= 1'b0;
            bus.RdData  <= '0;
            bus.RdValid <= '0;
        end else begin
            if (tag_push)
                tag_wr <= tag_wr + TW'(1);
            if (tag_pop)
                tag_rd <= tag_rd + TW'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + CW'(1);
                2'b01:   tag_cnt <= tag_cnt - CW'(1);
                default: tag_cnt <= tag_cnt;
            endcase
            if (rb_go)
                ret_cnt <= tag_pop ? '0 : ret_cnt + BW'(1);
            // read data with nobody waiting for it is left in the RB and flagged
            if (!bus.RBempty && tag_empty)
                orphan <= 1'b1;
            bus.RdValid <= rb_go ? head_oh : '0;
            if (rb_go)
                bus.RdData <= bus.ReadData;
        end
    end
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: a cycle table for single read/write bursts, then
// hand-written sequences for round-robin, tag-FIFO full, orphan and reset corner cases.
module tb_ddr_port_arbiter;
    localparam int NP = 4;
    localparam int BEATS = 2;
    localparam int TD = 16;
    localparam logic [127:0] DA = {4{32'hA0A0_0001}};
    localparam logic [127:0] DB = {4{32'hB0B0_0002}};

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    ddr_port_arbiter_if #(.NPORTS(NP)) bus();
    ddr_port_arbiter #(.NPORTS(NP), .BEATS(BEATS), .TAGDEPTH(TD)) dut (
        .CLK(CLK), .Reset(Reset), .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int wbeat [NP];

    function automatic logic [27:0] paddr(int p);
        case (p)
            0: return 28'h0000100;
            1: return 28'h0123456;
            2: return 28'h0ABCDE0;
            default: return 28'hFFFFFF0;
        endcase
    endfunction

    function automatic logic [127:0] wdat(int p, int b);
        return {32'(p), 32'(b), 32'hA5A5_0000 | 32'(p), 32'h5A5A_0000 | 32'(b)};
    endfunction

    function automatic logic [127:0] rdat(int n);
        return {4{32'hBEEF_0000 + 32'(n)}};
    endfunction

    always @(posedge CLK)
        for (int i = 0; i < NP; i++)
            wbeat[i] <= Reset ? 0 : (bus.WTake[i] ? wbeat[i] + 1 : wbeat[i]);

    always_comb
        for (int i = 0; i < NP; i++) begin
            bus.ReqWData[i] = wdat(i, wbeat[i]);
            bus.ReqAddr[i]  = paddr(i);
        end

    typedef struct {
        logic [NP-1:0] req, rd;
        logic          aff, wbf, rbe;
        logic [127:0]  rdat_in;
        logic          e_af, e_wb, e_rb, e_read;
        logic [NP-1:0] e_grant, e_wtake, e_rdv;
        int            e_wbeat;
        logic [127:0]  e_rdd;
    } vec_t;

    function automatic vec_t mk(logic [NP-1:0] req, logic [NP-1:0] rd, logic aff, logic wbf,
                                logic rbe, logic [127:0] rdi, logic eaf, logic ewb, logic erb,
                                logic erd, logic [NP-1:0] eg, logic [NP-1:0] ewt,
                                logic [NP-1:0] erv, int ewbeat, logic [127:0] erdd);
        vec_t v;
        v.req = req; v.rd = rd; v.aff = aff; v.wbf = wbf; v.rbe = rbe; v.rdat_in = rdi;
        v.e_af = eaf; v.e_wb = ewb; v.e_rb = erb; v.e_read = erd;
        v.e_grant = eg; v.e_wtake = ewt; v.e_rdv = erv; v.e_wbeat = ewbeat; v.e_rdd = erdd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [14:0] strobes();
        return {bus.WriteAF, bus.WriteWB, bus.ReadRB, bus.Grant, bus.WTake, bus.RdValid};
    endfunction

    task automatic idle_inputs();
        bus.Req = '0; bus.ReqRead = '0; bus.AFfull = 1'b0; bus.WBfull = 1'b0;
        bus.RBempty = 1'b1; bus.ReadData = '0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset(input string nm);
        Reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk({nm, " reset strobes/orphan"}, {strobes(), bus.Orphan}, 16'h0);
        chk({nm, " reset rddata"}, bus.RdData, 128'h0);
        tick();
        Reset = 1'b0;
    endtask

    // on return with cyc>=0 the caller sits at the negedge of the grant cycle
    task automatic wait_grant(input int p, output int cyc);
        cyc = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (bus.Grant[p]) begin
                cyc = c;
                break;
            end
            tick();
        end
    endtask

    vec_t vt [14];
    int   order [$];
    int   rv_port [$];
    logic [127:0] rv_data [$];

    initial begin
        int cyc, g0, g1, n;
        idle_inputs();

        vt[0]  = mk(4'b0010, 4'b0010, 0, 0, 1, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vt[1]  = mk(4'b0010, 4'b0010, 0, 0, 1, 0,  1, 0, 0, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0);
        vt[2]  = mk(4'b0000, 4'b0000, 0, 0, 0, DA, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vt[3]  = mk(4'b0000, 4'b0000, 0, 0, 0, DB, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0010, 0, DA);
        vt[4]  = mk(4'b0000, 4'b0000, 0, 0, 1, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0010, 0, DB);
        vt[5]  = mk(4'b0000, 4'b0000, 0, 0, 1, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vt[6]  = mk(4'b0100, 4'b0000, 0, 0, 1, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vt[7]  = mk(4'b0100, 4'b0000, 0, 1, 1, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vt[8]  = mk(4'b0100, 4'b0000, 0, 1, 1, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vt[9]  = mk(4'b0100, 4'b0000, 0, 1, 1, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vt[10] = mk(4'b0100, 4'b0000, 0, 0, 1, 0,  0, 1, 0, 0, 4'b0000, 4'b0100, 4'b0000, 0, 0);
        vt[11] = mk(4'b0100, 4'b0000, 0, 0, 1, 0,  0, 1, 0, 0, 4'b0000, 4'b0100, 4'b0000, 1, 0);
        vt[12] = mk(4'b0100, 4'b0000, 0, 0, 1, 0,  1, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0);
        vt[13] = mk(4'b0000, 4'b0000, 0, 0, 1, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        do_reset("t0");
        for (int r = 0; r < 14; r++) begin
            bus.Req = vt[r].req; bus.ReqRead = vt[r].rd; bus.AFfull = vt[r].aff;
            bus.WBfull = vt[r].wbf; bus.RBempty = vt[r].rbe; bus.ReadData = vt[r].rdat_in;
            @(negedge CLK);
            chk($sformatf("row%0d strobes", r), strobes(),
                {vt[r].e_af, vt[r].e_wb, vt[r].e_rb, vt[r].e_grant, vt[r].e_wtake, vt[r].e_rdv});
            if (vt[r].e_af) begin
                for (int p = 0; p < NP; p++)
                    if (vt[r].e_grant[p]) chk($sformatf("row%0d address", r), bus.Address, paddr(p));
                chk($sformatf("row%0d read", r), bus.Read, vt[r].e_read);
            end
            for (int p = 0; p < NP; p++)
                if (vt[r].e_wtake[p])
                    chk($sformatf("row%0d wdata", r), bus.WriteData, wdat(p, vt[r].e_wbeat));
            if (vt[r].e_rdv != '0)
                chk($sformatf("row%0d rddata", r), bus.RdData, vt[r].e_rdd);
            tick();
        end

        // four ports reading continuously: grant order then steering of interleaved returns
        do_reset("t3");
        bus.Req = 4'b1111; bus.ReqRead = 4'b1111;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            @(negedge CLK);
            for (int p = 0; p < NP; p++)
                if (bus.Grant[p]) order.push_back(p);
            if (order.size() == 5) bus.Req = '0;
            tick();
        end
        chk("rr grant count", 32'(order.size()), 32'd5);
        for (int k = 0; k < order.size(); k++)
            chk($sformatf("rr grant %0d", k), 32'(order[k]), 32'(k % 4));
        n = 0;
        for (int c = 0; c < 24; c++) begin
            if (c < 20 && c % 2 == 0) begin
                bus.RBempty = 1'b0; bus.ReadData = rdat(n); n++;
            end else begin
                bus.RBempty = 1'b1; bus.ReadData = '0;
            end
            @(negedge CLK);
            for (int p = 0; p < NP; p++)
                if (bus.RdValid[p]) begin
                    rv_port.push_back(p);
                    rv_data.push_back(bus.RdData);
                end
            tick();
        end
        chk("rr return count", 32'(rv_port.size()), 32'd10);
        for (int k = 0; k < rv_port.size() && k < 10; k++) begin
            chk($sformatf("rr return port %0d", k), 32'(rv_port[k]), 32'(order[k / 2]));
            chk($sformatf("rr return data %0d", k), rv_data[k], rdat(k));
        end

        // tag FIFO full: reads blocked, write on another port proceeds
        do_reset("t4");
        bus.Req = 4'b0001; bus.ReqRead = 4'b0001;
        g0 = 0;
        for (int c = 0; c < 100 && g0 < 16; c++) begin
            @(negedge CLK);
            if (bus.Grant[0]) g0++;
            if (g0 == 16) bus.Req = 4'b0011;
            tick();
        end
        chk("full read grants", 32'(g0), 32'd16);
        g0 = 0; g1 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (bus.Grant[0]) g0++;
            if (bus.Grant[1]) begin g1++; bus.Req[1] = 1'b0; end
            tick();
        end
        chk("full 17th read withheld", 32'(g0), 32'd0);
        chk("full write granted", 32'(g1), 32'd1);
        bus.RBempty = 1'b0; bus.ReadData = DA;
        @(negedge CLK);
        chk("full pop1", {bus.ReadRB, bus.Grant}, {1'b1, 4'b0000});
        tick();
        bus.ReadData = DB;
        @(negedge CLK);
        chk("full pop2", {bus.ReadRB, bus.Grant}, {1'b1, 4'b0000});
        tick();
        bus.RBempty = 1'b1;
        @(negedge CLK);
        chk("full return steer", {bus.RdValid, bus.Grant}, {4'b0001, 4'b0000});
        tick();
        @(negedge CLK);
        chk("full read reenabled", bus.Grant, 4'b0001);
        bus.Req = '0;
        tick();

        // orphan read data
        do_reset("t5");
        bus.RBempty = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("orphan readrb %0d", c), bus.ReadRB, 1'b0);
            tick();
        end
        chk("orphan set", bus.Orphan, 1'b1);
        bus.RBempty = 1'b1;
        repeat (3) tick();
        chk("orphan sticky", bus.Orphan, 1'b1);

        // reset in the middle of a write burst with one read outstanding
        do_reset("t6");
        bus.Req = 4'b0001; bus.ReqRead = 4'b0001;
        wait_grant(0, cyc);
        chk("t6 read grant", 32'(cyc >= 0), 32'd1);
        bus.Req = 4'b0100; bus.ReqRead = 4'b0000; bus.WBfull = 1'b1;
        repeat (4) tick();
        bus.WBfull = 1'b0;
        @(negedge CLK);
        chk("t6 in wdata", bus.WTake, 4'b0100);
        tick();
        Reset = 1'b1;
        @(negedge CLK);
        chk("t6 strobes during reset", strobes(), 15'h0);
        tick();
        Reset = 1'b0; bus.Req = '0; bus.RBempty = 1'b0;
        @(negedge CLK);
        chk("t6 after reset strobes", strobes(), 15'h0);
        tick();
        @(negedge CLK);
        chk("t6 idle tag empty", {strobes(), bus.Orphan}, 16'h1);
        tick();

        // simultaneous reads on ports 3 and 0
        do_reset("t7");
        bus.Req = 4'b1001; bus.ReqRead = 4'b1001;
        order.delete();
        for (int c = 0; c < 20 && order.size() < 2; c++) begin
            @(negedge CLK);
            for (int p = 0; p < NP; p++)
                if (bus.Grant[p]) order.push_back(p);
            tick();
        end
        bus.Req = '0;
        chk("pri grant count", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("pri first grant", 32'(order[0]), 32'd0);
`ifdef DDR_ARB_FIXED_PRI_EN
            chk("pri second grant", 32'(order[1]), 32'd0);
`else
            chk("pri second grant", 32'(order[1]), 32'd3);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Shares the single DDR2 controller command/data interface (address FIFO, write buffer, read buffer) among NPORTS client requesters, replacing the single Tester connection. Each request is either a read or a write of one BEATS×128-bit burst. Read data returns in issue order and is steered back to the originating port through an internal tag FIFO. Sits on the CLK domain between client logic and `ddrController`.

## Interface
- NPORTS, 4: number of requesters (2..8).
- BEATS, 2: 128-bit beats per burst (read and write).
- TAGDEPTH, 16: outstanding-read tag FIFO depth (power of 2, ≥2).
- CLK  in  1  system clock (MCLK/2); all logic on its rising edge.
- Reset  in  1  synchronous, active-high.
- Req  in  NPORTS  per-port request; held with ReqRead/ReqAddr stable until Grant.
- ReqRead  in  NPORTS  1 = read, 0 = write.
- ReqAddr  in  NPORTS*28  per-port burst address; port i at [28i+27:28i].
- ReqWData  in  NPORTS*128  per-port current write beat; advances after each WTake.
- Grant  out  NPORTS  one-cycle pulse: command entered the address FIFO.
- WTake  out  NPORTS  one-cycle pulse per write beat consumed.
- RdData  out  128  returned read beat (shared by all ports).
- RdValid  out  NPORTS  one-hot qualifier for RdData.
- Orphan  out  1  sticky: RB non-empty with no outstanding tag.
- Address  out  28, Read  out  1, WriteAF  out  1, AFfull  in  1: controller address FIFO.
- WriteData  out  128, WriteWB  out  1, WBfull  in  1: controller write buffer.
- ReadData  in  128, ReadRB  out  1, RBempty  in  1: controller read buffer (first-word-fall-through).

## Operation
- FSM states: IDLE, WDATA, ISSUE. Registers: winner index, beat counter, round-robin pointer, tag FIFO (count 0..TAGDEPTH), return beat counter.
- IDLE: eligible = Req[i] & (~ReqRead[i] | tag FIFO not full). Pick first eligible port at or after the RR pointer (wrapping). No eligible port: stay. Write winner → WDATA; read winner → ISSUE. Winner address/read flag latched.
- WDATA: each cycle with ~WBfull: WriteWB=1, WriteData=ReqWData[winner], WTake[winner]=1, beat counter++. After beat BEATS → ISSUE. WBfull stalls without consuming.
- ISSUE: when ~AFfull: WriteAF=1, Address/Read from latch, Grant[winner]=1; read pushes winner index into tag FIFO; RR pointer ← winner+1 mod NPORTS; → IDLE. Write data always precedes its address-FIFO entry.
- Return path (independent of FSM): ReadRB = ~RBempty & tag FIFO non-empty. Each pop: RdData ← ReadData, RdValid[head tag] = 1 next cycle. After BEATS pops the head tag is dequeued. Tag push and pop in the same cycle: count unchanged.
- ~RBempty with tag FIFO empty: ReadRB held 0, Orphan set (sticky until Reset).
- WriteAF, WriteWB, ReadRB, Grant, WTake are combinational from state registers and full/empty flags. RdData/RdValid are registered.

## Timing
- Reset: state IDLE, RR pointer 0, counters 0, tag FIFO empty, Orphan 0, RdValid 0, RdData 0; all strobes 0 while Reset is high. Reset mid-burst abandons it; partial WB contents are cleared by the controller reset.
- Read, no backpressure: Req seen in IDLE (cycle 0), WriteAF+Grant at cycle 1, minimum spacing 2 cycles per command.
- Write: IDLE cycle 0, beats cycles 1..BEATS, WriteAF+Grant cycle BEATS+1.
- Return latency: RdValid one cycle after the ReadRB pop; back-to-back beats at one per cycle.
- Read grant is withheld in IDLE when the tag count equals TAGDEPTH, even if a pop is in progress that cycle.

## Configuration
- DDR_ARB_FIXED_PRI_EN defined: IDLE picks the lowest-index eligible port (port 0 highest) and the RR pointer is unused (fixed at 0).
- Not defined: round-robin as described above.

## Test plan
- Single read port 1, addr 28'h0123456: WriteAF=1, Read=1, Address=28'h0123456, Grant[1] at cycle 1; RB supplies 2 beats A,B → RdValid=4'b0010 with RdData A then B.
- Write port 2, beats X,Y, WBfull high for 3 cycles at beat 1: WTake[2] only when WBfull low, WriteWB count=2, WriteAF (Read=0) after the last beat, Grant[2] once.
- All 4 ports requesting reads continuously: grants cycle 0,1,2,3,0; returns from an interleaved RB are steered to the same order.
- 16 outstanding reads with RB empty: the 17th read is not granted while a write on another port is granted; one full 2-beat return re-enables reads.
- RBempty=0 with no outstanding read: ReadRB stays 0, Orphan=1 until Reset.
- Reset asserted mid-WDATA: next cycle all strobes 0, FSM in IDLE, tag count 0; with the macro defined, simultaneous requests on ports 3 and 0 always grant 0 first.
